// File: rtl/uart_pkg.sv
//==============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver state encoding, frame
//               constants and the baud divisor helper (also used by TX).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // Clock cycles per serial symbol; truncating division is intentional.
    function automatic int symbol_ticks(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_deserializer_bit_sync.sv
//==============================================================================
// Module      : bit_sync
// Description : Two-flop synchroniser for a single asynchronous input, with a
//               configurable reset value so an idle line reads correctly.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bit_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
//==============================================================================
// Module      : uart_rx_deserializer
// Description : 8N1 UART receiver with start-glitch rejection, mid-bit
//               sampling, stop-bit check and a one-byte valid/ready holding
//               register. Optional macro UART_RX_FRAMING_ERR_EN adds a
//               framing_error pulse output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       overrun
`ifdef UART_RX_FRAMING_ERR_EN
    ,
    output logic       framing_error
`endif
);

    localparam int SYMBOL_TICKS = symbol_ticks(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TICKS = SYMBOL_TICKS / 2;
    localparam int CNT_W        = $clog2(SYMBOL_TICKS + 1);

    localparam logic [CNT_W-1:0] c_symbol_last = CNT_W'(SYMBOL_TICKS - 1);
    localparam logic [CNT_W-1:0] c_sample_last = CNT_W'(SAMPLE_TICKS - 1);
    localparam logic [CNT_W-1:0] c_bit_last    = CNT_W'(DATA_BITS - 1);

    generate
        if (SYMBOL_TICKS < 4) begin : g_param_check
            $error("uart_rx_deserializer: CLOCK_FREQ/BAUD_RATE must be >= 4");
        end
    endgenerate

    logic                 w_rx;
    rx_state_e            r_state;
    logic [CNT_W-1:0]     r_tick_cnt;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_overrun;
    logic                 r_framing_error;

    bit_sync #(
        .RESET_VAL (IDLE_LEVEL)
    ) u_rx_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (serial_in),
        .o_sync  (w_rx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_tick_cnt      <= '0;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_data          <= '0;
            r_valid         <= 1'b0;
            r_overrun       <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_overrun       <= 1'b0;
            r_framing_error <= 1'b0;

            // Consumer drain; a byte landing this same cycle overrides below.
            if (r_valid && data_out_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_rx != IDLE_LEVEL) begin
                        r_state    <= START;
                        r_tick_cnt <= '0;
                    end
                end

                START: begin
                    if (r_tick_cnt == c_sample_last) begin
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= (w_rx == IDLE_LEVEL) ? IDLE : DATA;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (r_tick_cnt == c_symbol_last) begin
                        r_tick_cnt <= '0;
                        // LSB arrives first, so shift in from the top.
                        r_shift    <= {w_rx, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == c_bit_last) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (r_tick_cnt == c_symbol_last) begin
                        r_tick_cnt <= '0;
                        // Return to IDLE at mid-stop so the next start edge
                        // is caught half a bit early.
                        r_state    <= IDLE;
                        if (w_rx == IDLE_LEVEL) begin
                            if (!r_valid || data_out_ready) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_framing_error <= 1'b1;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_tick_cnt <= '0;
                end
            endcase
        end
    end

    assign data_out       = r_data;
    assign data_out_valid = r_valid;
    assign overrun        = r_overrun;

`ifdef UART_RX_FRAMING_ERR_EN
    assign framing_error  = r_framing_error;
`else
    logic w_unused_framing;
    assign w_unused_framing = r_framing_error;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
//==============================================================================
// Module      : tb_uart_rx_deserializer
// Description : Directed self-checking bench for uart_rx_deserializer at
//               SYMBOL_TICKS=10, SAMPLE_TICKS=5 (table vectors plus corner cases).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_rx_deserializer;

    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int SYM        = 10;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       overrun;
    logic       framing_error;

    int n_checks;
    int n_errors;
    int cyc;
    int rise_cyc;
    int ovr_cnt;
    int fe_cnt;
    logic prev_valid;
    logic [7:0] acc_q[$];
    vec_t vecs[6];

    uart_rx_deserializer #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .overrun        (overrun)
`ifdef UART_RX_FRAMING_ERR_EN
        ,
        .framing_error  (framing_error)
`endif
    );

`ifndef UART_RX_FRAMING_ERR_EN
    assign framing_error = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (data_out_valid && data_out_ready) acc_q.push_back(data_out);
            if (overrun) ovr_cnt++;
            if (framing_error) fe_cnt++;
            if (data_out_valid && !prev_valid) rise_cyc = cyc;
        end
        prev_valid = data_out_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start bit, 8 data bits LSB first, stop bit; SYM cycles each.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serial_in = f[i];
            tick(SYM);
        end
    endtask

    initial begin
        int start_cyc;
        int lat;
        int ovr0;
        int fe0;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5};
        vecs[1] = '{8'h55, 1'b0, 1'b0, 8'hA5};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 8'hFF};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 8'h81};

        n_checks = 0; n_errors = 0; cyc = 0; rise_cyc = -1;
        ovr_cnt = 0; fe_cnt = 0; prev_valid = 1'b0;
        rst = 1'b1; serial_in = 1'b1; data_out_ready = 1'b0;
        tick(4);
        check("reset_valid", {31'b0, data_out_valid}, 32'h0);
        check("reset_data", {24'b0, data_out}, 32'h00);
        check("reset_overrun", {31'b0, overrun}, 32'h0);
        check("reset_framing", {31'b0, framing_error}, 32'h0);
        rst = 1'b0;
        tick(5);

        // A5 with ready low: latency and hold, then a single-cycle drain.
        start_cyc = cyc;
        rise_cyc  = -1;
        send_frame(8'hA5, 1'b1);
        lat = rise_cyc - start_cyc;
        n_checks++;
        if (lat < 97 || lat > 99) begin
            n_errors++;
            $display("FAIL latency: actual=%0d required=98 (+/-1)", lat);
        end
        check("a5_valid", {31'b0, data_out_valid}, 32'h1);
        check("a5_data", {24'b0, data_out}, 32'hA5);
        data_out_ready = 1'b1;
        tick(1);
        data_out_ready = 1'b0;
        check("a5_drain_valid", {31'b0, data_out_valid}, 32'h0);
        check("a5_drain_data", {24'b0, data_out}, 32'hA5);

        // Three-cycle low glitch on an idle line.
        ovr0 = ovr_cnt;
        serial_in = 1'b0;
        tick(3);
        serial_in = 1'b1;
        tick(30);
        check("glitch_valid", {31'b0, data_out_valid}, 32'h0);
        check("glitch_overrun", ovr_cnt - ovr0, 32'h0);

        for (int v = 0; v < 6; v++) begin
            fe0 = fe_cnt;
            send_frame(vecs[v].data, vecs[v].stop);
            serial_in = 1'b1;
            tick(3);
            check($sformatf("vec%0d_valid", v), {31'b0, data_out_valid}, {31'b0, vecs[v].exp_valid});
            check($sformatf("vec%0d_data", v), {24'b0, data_out}, {24'b0, vecs[v].exp_data});
`ifdef UART_RX_FRAMING_ERR_EN
            check($sformatf("vec%0d_framing", v), fe_cnt - fe0, {31'b0, ~vecs[v].stop});
`endif
            data_out_ready = 1'b1;
            tick(1);
            data_out_ready = 1'b0;
            check($sformatf("vec%0d_after_ready", v), {31'b0, data_out_valid}, 32'h0);
            tick(10);
        end

        // Back-to-back 00, FF with ready held high.
        acc_q.delete();
        data_out_ready = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(5);
        data_out_ready = 1'b0;
        check("b2b_count", acc_q.size(), 32'd2);
        if (acc_q.size() == 2) begin
            check("b2b_first", {24'b0, acc_q[0]}, 32'h00);
            check("b2b_second", {24'b0, acc_q[1]}, 32'hFF);
        end
        check("b2b_valid", {31'b0, data_out_valid}, 32'h0);
        tick(10);

        // 3C then C3 with ready low: second byte dropped with overrun.
        ovr0 = ovr_cnt;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        tick(3);
        check("ovr_pulses", ovr_cnt - ovr0, 32'd1);
        check("ovr_data", {24'b0, data_out}, 32'h3C);
        check("ovr_valid", {31'b0, data_out_valid}, 32'h1);
        tick(10);

        // Reset during bit 4 of 81, held until the line is idle again.
        ovr0 = ovr_cnt;
        fork
            send_frame(8'h81, 1'b1);
            begin
                tick(52);
                rst = 1'b1;
                tick(2);
                check("rst_valid", {31'b0, data_out_valid}, 32'h0);
                check("rst_data", {24'b0, data_out}, 32'h00);
                check("rst_overrun", {31'b0, overrun}, 32'h0);
            end
        join
        tick(2);
        rst = 1'b0;
        tick(30);
        check("post_rst_idle", {31'b0, data_out_valid}, 32'h0);
        send_frame(8'h7E, 1'b1);
        tick(3);
        check("post_rst_valid", {31'b0, data_out_valid}, 32'h1);
        check("post_rst_data", {24'b0, data_out}, 32'h7E);
        check("post_rst_overrun", ovr_cnt - ovr0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
